// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_adder_fulladd.sv
// Single-bit full-adder cell, purely combinational.
// Reused once per bit by the serial adder datapath.
module fulladd (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder, LSB first through one full-adder cell; ovf port under SERIAL_ADDER_OVF_EN.
// Latency: operands accepted at edge T, result valid after edge T+WIDTH.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);

   state_e           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             fa_s;
   logic             fa_co;
   logic             last_bit;

   assign last_bit = (cnt == CW'(WIDTH - 1));

   fulladd u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .c  (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
               sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= fa_co;
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic msb_cin;

   // Carry into the MSB; differs from carry out exactly on signed overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msb_cin <= 1'b0;
      end else if (state == ST_RUN && last_bit) begin
         msb_cin <= carry;
      end
   end

   assign ovf = msb_cin ^ carry;
`endif

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign sum       = sum_sh;
   assign cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized operands vs an arithmetic model.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits for out_valid (sampled 1 time unit after each edge); returns edges elapsed.
   task automatic wait_result(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tc);
      logic [W:0] full;
      full = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_sum"}, sum, full[W-1:0]);
      chk({tag, "_cout"}, cout, full[W]);
`ifdef SERIAL_ADDER_OVF_EN
      chk({tag, "_ovf"}, ovf, (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]));
`endif
   endtask

   // One full transaction; hold = cycles out_ready is kept low once DONE is seen.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input int hold);
      int n;
      logic [W-1:0] s0;
      logic c0;
      n = 0;
      while (in_ready !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_rdy_idle"}, in_ready, 1'b1);
      @(negedge clk);
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      chk({tag, "_rdy_run"}, in_ready, 1'b0);
      wait_result(n);
      chk({tag, "_latency"}, n, W);
      check_result(tag, ta, tb, tc);
      s0 = sum; c0 = cout;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, out_valid, 1'b1);
         chk({tag, "_hold_sum"}, sum, s0);
         chk({tag, "_hold_cout"}, cout, c0);
         chk({tag, "_hold_rdy"}, in_ready, 1'b0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_after_valid"}, out_valid, 1'b0);
      chk({tag, "_after_rdy"}, in_ready, 1'b1);
   endtask

   initial begin
      int lat;
      logic [W-1:0] ra, rb;
      logic rc;

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
      #12;
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_sum", sum, 0);
      chk("reset_cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("reset_ovf", ovf, 1'b0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      run_op("basic", 8'h3C, 8'h25, 1'b0, 0);
      run_op("wrap", 8'hFF, 8'h01, 1'b0, 0);
      run_op("allones", 8'hFF, 8'hFF, 1'b1, 0);
      run_op("pos_ovf", 8'h7F, 8'h01, 1'b0, 0);
      run_op("neg_ovf", 8'h80, 8'h80, 1'b0, 0);
      run_op("no_ovf", 8'h10, 8'h20, 1'b0, 0);
      run_op("hold", 8'hA5, 8'h5A, 1'b1, 5);

      // New operands offered during RUN must not disturb the in-flight add.
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      a = 8'hEE; b = 8'hDD; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("ign_rdy", in_ready, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_result(lat);
      chk("ign_latency", lat, W - 4);
      check_result("ign", 8'h12, 8'h34, 1'b1);
      @(posedge clk); #1;
      chk("ign_back_idle", in_ready, 1'b1);
      run_op("ign_next", 8'hEE, 8'hDD, 1'b0, 0);

      // Reset in the middle of RUN discards the operation.
      @(negedge clk);
      a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", out_valid, 1'b0);
      chk("rst_mid_rdy", in_ready, 1'b1);
      chk("rst_mid_sum", sum, 0);
      chk("rst_mid_cout", cout, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", 8'h01, 8'h02, 1'b0, 0);

      for (int i = 0; i < 25; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         run_op("rand", ra, rb, rc, (i % 4 == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial two's-complement adder, the addition counterpart to the team's full-subtractor cell. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop, then presents sum and carry-out on a valid/ready output. It sits in low-area datapaths where one adder cell reused over WIDTH cycles is preferred to a ripple array.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  augend.
- b  input  WIDTH  addend.
- cin  input  1  carry-in.
- out_valid  output  1  sum, cout (and ovf) are valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow; present only when SERIAL_ADDER_OVF_EN is defined.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a and b into shift registers and cin into the carry flop, clear bit counter, go to RUN.
- RUN: each cycle feed a_sh[0], b_sh[0] and the carry flop to the full-adder cell. Shift its sum bit into sum_sh from the MSB side. Shift a_sh and b_sh right. Load the carry flop with the cell's carry-out. Increment the counter.
- RUN to DONE on the cycle the counter equals WIDTH-1.
- DONE: out_valid=1; sum=sum_sh; cout=carry flop. Outputs stay stable until out_ready is high. DONE to IDLE on out_valid&&out_ready.
- in_valid in RUN or DONE is ignored; in_ready=0; operand inputs are not sampled.
- No same-cycle bypass from DONE to accept: in_ready rises the cycle after the result handshake.
- Arithmetic: result is exactly {cout,sum} = a + b + cin, as a (WIDTH+1)-bit unsigned value.
- Counter width is $clog2(WIDTH). The counter never wraps in operation; it is cleared on every accept.

## Timing
- Reset (async assert, sync deassert by the upstream reset synchroniser) forces state IDLE, counter 0, all shift registers 0, carry flop 0.
- Output values at reset: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
- Latency: operands accepted at edge T; out_valid rises after edge T+WIDTH.
- Throughput: one result per WIDTH+2 cycles with out_ready held high (accept, WIDTH RUN cycles, DONE, IDLE).
- Reset asserted mid-RUN or in DONE: in-flight operation is discarded; no out_valid pulse; outputs return to reset values immediately.
- out_ready held low: DONE persists indefinitely with stable outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - adds the ovf port and a one-bit flop that captures the carry into the MSB on the last RUN cycle.
  - ovf = that flop XOR cout, valid with out_valid.
  - ovf resets to 0.
- Not defined: no ovf port and no extra flop; all other behaviour identical.

## Structure
- Package serial_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE), 2-bit encoding.
  - default WIDTH constant.
- One sub-module, fulladd: combinational cell with s = a^b^c and co = a&b | a&c | b&c.
- serial_adder instantiates exactly one fulladd.

## Test plan
All scenarios at WIDTH=8.
- a=0x3C, b=0x25, cin=0, out_ready=1 -> sum=0x61, cout=0; out_valid exactly 8 cycles after the accept edge.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1; a=0x10, b=0x20 -> ovf=0.
- out_ready held low 5 cycles in DONE -> out_valid, sum and cout stay constant; in_ready=0 throughout.
- Second in_valid with new operands during RUN -> ignored; the first result is delivered unchanged; the new operands are accepted only after return to IDLE.
- rst_n pulsed low at RUN cycle 4 -> out_valid=0, in_ready=1 immediately; next operation 0x01+0x02 -> sum=0x03 (no residue from the aborted carry).
